// File: rtl/adc_prime_filter_pkg.sv
// Shared types and helpers for the multi-channel ADC prime-class filter.
package adc_prime_filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOC,
    CONV,
    ADDR,
    WAIT,
    CHECK,
    DAV,
    ACK
  } state_e;

  // Accepts class codes 2,3,5,7,11,13.
  localparam logic [15:0] ACCEPT_MASK_DEFAULT = 16'h28AC;

  // Magnitude of a sign-extended sample; callers truncate to their width,
  // which maps the most negative value onto itself.
  function automatic logic [63:0] abs_w(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/adc_prime_filter_mc_if.sv
// Bundles the ADC, EPROM and consumer signals of adc_prime_filter_mc.
interface adc_prime_filter_mc_if #(
  parameter int W      = 8,
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int CODE_W = 4
);
  logic [NCH-1:0]    chen;
  logic [CH_W-1:0]   chsel;
  logic              soc;
  logic              eoc;
  logic [W-1:0]      x;
  logic [W-1:0]      addr;
  logic              mr_;
  logic [CODE_W-1:0] d;
  logic              dav_;
  logic              rfd;
  logic [W-1:0]      y;
  logic [CH_W-1:0]   ych;
  logic              err;

  modport master (
    input  chen, eoc, x, d, rfd,
    output chsel, soc, addr, mr_, dav_, y, ych, err
  );

  modport slave (
    output chen, eoc, x, d, rfd,
    input  chsel, soc, addr, mr_, dav_, y, ych, err
  );
endinterface

// File: rtl/adc_prime_filter_mc_rr_arbiter_next.sv
// Finds the first enabled channel strictly after ptr, wrapping NCH-1 -> 0.
module rr_arbiter_next #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  chen,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] ch,
  output logic            valid
);

  logic [CH_W-1:0] cand [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    assign cand[gi] = CH_W'((int'(ptr) + gi + 1) % NCH);
  end

  // Scan from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    ch    = '0;
    valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chen[cand[i]]) begin
        ch    = cand[i];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_prime_filter_mc.sv
// Round-robin multi-channel ADC sampler that forwards samples whose EPROM class
// code is in ACCEPT_MASK. Define ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN for the EOC timeout.
module adc_prime_filter_mc
  import adc_prime_filter_pkg::*;
#(
  parameter int W      = 8,
  parameter int NCH    = 4,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int CODE_W = 4,
  parameter logic [(1<<CODE_W)-1:0] ACCEPT_MASK = ACCEPT_MASK_DEFAULT,
  parameter int MEM_LAT = 2
`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
  , parameter int TMO = 64
`endif
) (
  input logic               clock,
  input logic               reset,
  adc_prime_filter_mc_if.master bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e          state_q, state_d;
  logic            soc_q, soc_d;
  logic            mr_n_q, mr_n_d;
  logic            dav_n_q, dav_n_d;
  logic [W-1:0]    addr_q, addr_d;
  logic [W-1:0]    y_q, y_d;
  logic [CH_W-1:0] ych_q, ych_d;
  logic [CH_W-1:0] chsel_q, chsel_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]    xs_q, xs_d;
  logic [CNT_W-1:0] lat_q, lat_d;

  logic [CH_W-1:0] arb_ch;
  logic            arb_valid;

`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  rr_arbiter_next #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_rr (
    .chen  (bus.chen),
    .ptr   (ptr_q),
    .ch    (arb_ch),
    .valid (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    soc_d   = soc_q;
    mr_n_d  = mr_n_q;
    dav_n_d = dav_n_q;
    addr_d  = addr_q;
    y_d     = y_q;
    ych_d   = ych_q;
    chsel_d = chsel_q;
    ptr_d   = ptr_q;
    xs_d    = xs_q;
    lat_d   = lat_q;
`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          chsel_d = arb_ch;
          ptr_d   = arb_ch;
          soc_d   = 1'b1;
          state_d = SOC;
`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      SOC: begin
        if (!bus.eoc) begin
          soc_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (bus.eoc) begin
          xs_d    = bus.x;
          state_d = ADDR;
        end
      end
      ADDR: begin
        addr_d  = W'(abs_w(64'($signed(xs_q))));
        mr_n_d  = 1'b0;
        lat_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // Release the strobe on leaving WAIT so it is low for exactly MEM_LAT clocks.
        if (lat_q == '0) begin
          mr_n_d  = 1'b1;
          state_d = CHECK;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      CHECK: begin
        if (ACCEPT_MASK[bus.d]) begin
          y_d     = xs_q;
          ych_d   = chsel_q;
          dav_n_d = 1'b0;
          state_d = DAV;
        end else begin
          state_d = IDLE;
        end
      end
      DAV: begin
        if (!bus.rfd) begin
          dav_n_d = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (bus.rfd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
    // A completed conversion in the same cycle as the deadline still counts.
    if (state_q == SOC || state_q == CONV) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_W'(TMO - 1) && state_d != ADDR) begin
        soc_d   = 1'b0;
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      soc_q   <= 1'b0;
      mr_n_q  <= 1'b1;
      dav_n_q <= 1'b1;
      addr_q  <= '0;
      y_q     <= '0;
      ych_q   <= '0;
      chsel_q <= '0;
      ptr_q   <= CH_W'(NCH - 1);
      xs_q    <= '0;
      lat_q   <= '0;
`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      mr_n_q  <= mr_n_d;
      dav_n_q <= dav_n_d;
      addr_q  <= addr_d;
      y_q     <= y_d;
      ych_q   <= ych_d;
      chsel_q <= chsel_d;
      ptr_q   <= ptr_d;
      xs_q    <= xs_d;
      lat_q   <= lat_d;
`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.soc   = soc_q;
  assign bus.mr_   = mr_n_q;
  assign bus.dav_  = dav_n_q;
  assign bus.addr  = addr_q;
  assign bus.y     = y_q;
  assign bus.ych   = ych_q;
  assign bus.chsel = chsel_q;
`ifdef ADC_PRIME_FILTER_MC_EOC_TIMEOUT_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule
